// File: rtl/urna_entrada.sv
// urna_entrada: conditions the raw DE2-115 pushbuttons and slide switches for
// the voting-machine core. Keys and switches are double-flopped, each key is
// debounced by its own FSM, and the resulting press events are arbitrated
// (Finish > Next > Valid) into registered single-cycle pulses. The block also
// counts the digits accepted for the current vote and ignores digits past four.
module urna_entrada #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       KeyValid_n,
  input  logic       KeyNext_n,
  input  logic       KeyFinish_n,
  input  logic [3:0] SwDigit,
  output logic [3:0] Digit,
  output logic       Valid,
  output logic       Next,
  output logic       Finish,
  output logic [2:0] DigitCount
);

  // Key bit order everywhere: [0] Valid, [1] Next, [2] Finish.
  logic [2:0] key_p0;
  logic [2:0] key_p1;
  logic [3:0] sw_p0;
  logic [3:0] sw_p1;
  logic [2:0] press;

  // Two-flop synchronisers; keys reset to released, switches to zero.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      key_p0 <= 3'b111;
      key_p1 <= 3'b111;
      sw_p0  <= 4'd0;
      sw_p1  <= 4'd0;
    end else begin
      // stage p0: first capture of the asynchronous pins
      key_p0 <= {KeyFinish_n, KeyNext_n, KeyValid_n};
      sw_p0  <= SwDigit;
      // stage p1: metastability-settled copy used by all downstream logic
      key_p1 <= key_p0;
      sw_p1  <= sw_p0;
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_deb
    urna_entrada_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .Clock (Clock),
      .Reset (Reset),
      .synced(key_p1[k]),
      .press (press[k])
    );
  end

  // Arbitrate coincident events and register the pulses, digit and count.
  // Losing events are dropped, never queued.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Valid      <= 1'b0;
      Next       <= 1'b0;
      Finish     <= 1'b0;
      Digit      <= 4'd0;
      DigitCount <= 3'd0;
    end else begin
      Valid  <= 1'b0;
      Next   <= 1'b0;
      Finish <= 1'b0;
      if (press[2]) begin
        Finish     <= 1'b1;
        DigitCount <= 3'd0;
      end else if (press[1]) begin
        Next       <= 1'b1;
        DigitCount <= 3'd0;
      end else if (press[0] && (DigitCount < 3'd4)) begin
        // Codes 10..15 are passed through; the core reads them as a null vote.
        Valid      <= 1'b1;
        Digit      <= sw_p1;
        DigitCount <= DigitCount + 3'd1;
      end
    end
  end

endmodule

// urna_entrada_debounce: press/release debouncer for one synchronised
// active-low key. A level must be seen for DEBOUNCE_CYCLES consecutive cycles
// to be accepted; 'press' is asserted combinationally in the cycle the press
// is accepted so the parent registers it on that same edge.
module urna_entrada_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic Clock,
  input  logic Reset,
  input  logic synced,
  output logic press
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // The count is bumped on the accepting edge, so acceptance is detected one
  // value early.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_nxt;

  // State and counter register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
    end
  end

  // Next-state, counter and press-event logic.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    press     = 1'b0;
    case (state)
      IDLE: begin
        if (!synced) begin
          state_nxt = PRESS_WAIT;
          count_nxt = CNT_W'(1);
        end
      end
      PRESS_WAIT: begin
        if (synced) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else if (count == LAST) begin
          state_nxt = PRESSED;
          count_nxt = '0;
          press     = 1'b1;
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (synced) begin
          state_nxt = RELEASE_WAIT;
          count_nxt = CNT_W'(1);
        end
      end
      RELEASE_WAIT: begin
        if (!synced) begin
          state_nxt = PRESSED;
          count_nxt = '0;
        end else if (count == LAST) begin
          state_nxt = IDLE;
          count_nxt = '0;
        end else begin
          count_nxt = count + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        count_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_urna_entrada.sv
// Testbench for urna_entrada with DEBOUNCE_CYCLES = 4: directed scenarios
// followed by random key/switch activity, all checked every cycle against a
// run-length reference model of the debounce and vote-count rules.
module tb_urna_entrada;

  localparam int D = 4;

  logic       Clock       = 1'b0;
  logic       Reset       = 1'b1;
  logic       KeyValid_n  = 1'b1;
  logic       KeyNext_n   = 1'b1;
  logic       KeyFinish_n = 1'b1;
  logic [3:0] SwDigit     = 4'd0;
  logic [3:0] Digit;
  logic       Valid;
  logic       Next;
  logic       Finish;
  logic [2:0] DigitCount;

  int checks = 0;
  int errors = 0;

  // Pulse counters observed from the DUT.
  int nv = 0;
  int nn = 0;
  int nf = 0;

  // Reference model state.
  logic [2:0] m_k0, m_k1;      // key sync pipeline, [0]=Valid [1]=Next [2]=Finish
  logic [3:0] m_sw0, m_sw1;
  logic [2:0] m_deb;           // accepted key level (1 = released)
  int         m_run [3];       // consecutive samples disagreeing with m_deb
  logic       m_valid, m_next, m_finish;
  logic [3:0] m_digit;
  int         m_cnt;

  urna_entrada #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (4)
  ) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .KeyValid_n (KeyValid_n),
    .KeyNext_n  (KeyNext_n),
    .KeyFinish_n(KeyFinish_n),
    .SwDigit    (SwDigit),
    .Digit      (Digit),
    .Valid      (Valid),
    .Next       (Next),
    .Finish     (Finish),
    .DigitCount (DigitCount)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
  endtask

  task automatic model_reset();
    m_k0 = 3'b111; m_k1 = 3'b111;
    m_sw0 = 4'd0;  m_sw1 = 4'd0;
    m_deb = 3'b111;
    for (int k = 0; k < 3; k++) m_run[k] = 0;
    m_valid = 1'b0; m_next = 1'b0; m_finish = 1'b0;
    m_digit = 4'd0; m_cnt = 0;
  endtask

  // One clock edge of behaviour: a key level is accepted once the settled key
  // has disagreed with the accepted level for D samples in a row.
  task automatic model_step();
    logic [2:0] ev;
    ev = 3'b000;
    for (int k = 0; k < 3; k++) begin
      if (m_k1[k] != m_deb[k]) begin
        m_run[k]++;
        if (m_run[k] == D) begin
          m_deb[k] = m_k1[k];
          m_run[k] = 0;
          ev[k]    = (m_deb[k] == 1'b0);
        end
      end else begin
        m_run[k] = 0;
      end
    end
    m_valid = 1'b0; m_next = 1'b0; m_finish = 1'b0;
    if (ev[2]) begin
      m_finish = 1'b1; m_cnt = 0;
    end else if (ev[1]) begin
      m_next = 1'b1; m_cnt = 0;
    end else if (ev[0] && m_cnt < 4) begin
      m_valid = 1'b1; m_digit = m_sw1; m_cnt = m_cnt + 1;
    end
    m_k1 = m_k0; m_sw1 = m_sw0;
    m_k0 = {KeyFinish_n, KeyNext_n, KeyValid_n};
    m_sw0 = SwDigit;
  endtask

  task automatic check_outputs();
    chk("Valid",      int'(Valid),      int'(m_valid));
    chk("Next",       int'(Next),       int'(m_next));
    chk("Finish",     int'(Finish),     int'(m_finish));
    chk("Digit",      int'(Digit),      int'(m_digit));
    chk("DigitCount", int'(DigitCount), m_cnt);
  endtask

  task automatic tick();
    @(posedge Clock);
    if (Reset) model_step(); else model_reset();
    @(negedge Clock);
    check_outputs();
    if (Valid)  nv++;
    if (Next)   nn++;
    if (Finish) nf++;
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic press_valid(input logic [3:0] d);
    SwDigit = d;
    KeyValid_n = 1'b0;
    hold(10);
    KeyValid_n = 1'b1;
    hold(12);
  endtask

  task automatic press_next();
    KeyNext_n = 1'b0;
    hold(10);
    KeyNext_n = 1'b1;
    hold(12);
  endtask

  initial begin
    int v0, n0, f0, first_at;

    // Reset state.
    #2 Reset = 1'b0;
    model_reset();
    #1;
    chk("reset_valid", int'(Valid), 0);
    chk("reset_digit", int'(Digit), 0);
    chk("reset_count", int'(DigitCount), 0);
    hold(3);
    Reset = 1'b1;
    hold(4);

    // Clean press: pulse exactly after edge 6, once, nothing on release.
    v0 = nv; first_at = 0;
    SwDigit = 4'd3;
    KeyValid_n = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (Valid && first_at == 0) first_at = i;
    end
    KeyValid_n = 1'b1;
    hold(12);
    chk("clean_edge",  first_at, 6);
    chk("clean_count", nv - v0, 1);
    chk("clean_digit", int'(Digit), 3);
    chk("clean_dcnt",  int'(DigitCount), 1);

    // Bounce on Next: no pulse, then one pulse on a solid hold.
    n0 = nn;
    KeyNext_n = 1'b0; hold(2);
    KeyNext_n = 1'b1; hold(1);
    KeyNext_n = 1'b0; hold(3);
    KeyNext_n = 1'b1; hold(8);
    chk("bounce_none", nn - n0, 0);
    KeyNext_n = 1'b0; hold(10);
    KeyNext_n = 1'b1; hold(12);
    chk("bounce_one",  nn - n0, 1);
    chk("bounce_dcnt", int'(DigitCount), 0);

    // Vote sequence with lockout on the fifth digit.
    v0 = nv;
    press_valid(4'd3);
    press_valid(4'd4);
    press_valid(4'd9);
    press_valid(4'd4);
    chk("vote_four",  nv - v0, 4);
    chk("vote_dcnt4", int'(DigitCount), 4);
    press_valid(4'd7);
    chk("lock_pulses", nv - v0, 4);
    chk("lock_digit",  int'(Digit), 4);
    chk("lock_dcnt",   int'(DigitCount), 4);
    press_next();
    chk("next_clear", int'(DigitCount), 0);

    // Simultaneous Finish and Valid: Finish wins, Valid dropped.
    press_valid(4'd5);
    v0 = nv; f0 = nf;
    SwDigit = 4'd8;
    KeyFinish_n = 1'b0; KeyValid_n = 1'b0;
    hold(10);
    KeyFinish_n = 1'b1; KeyValid_n = 1'b1;
    hold(12);
    chk("simul_finish", nf - f0, 1);
    chk("simul_valid",  nv - v0, 0);
    chk("simul_dcnt",   int'(DigitCount), 0);
    chk("simul_digit",  int'(Digit), 5);

    // Reset mid-debounce with the key still held through reset.
    v0 = nv; first_at = 0;
    SwDigit = 4'd6;
    KeyValid_n = 1'b0;
    hold(3);
    Reset = 1'b0;
    model_reset();
    #1;
    chk("rst_mid_valid", int'(Valid), 0);
    chk("rst_mid_digit", int'(Digit), 0);
    chk("rst_mid_dcnt",  int'(DigitCount), 0);
    hold(2);
    Reset = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (Valid && first_at == 0) first_at = i;
    end
    KeyValid_n = 1'b1;
    hold(12);
    chk("rst_edge",  first_at, 6);
    chk("rst_count", nv - v0, 1);
    chk("rst_digit", int'(Digit), 6);

    // Out-of-range digit passes through.
    press_valid(4'd12);
    chk("oor_digit", int'(Digit), 12);
    chk("oor_dcnt",  int'(DigitCount), 2);

    // Random activity checked cycle by cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) KeyValid_n  = ~KeyValid_n;
      if ($urandom_range(11) == 0) KeyNext_n  = ~KeyNext_n;
      if ($urandom_range(15) == 0) KeyFinish_n = ~KeyFinish_n;
      if ($urandom_range(3) == 0) SwDigit = 4'($urandom_range(15));
      if ($urandom_range(699) == 0) begin
        Reset = 1'b0;
        model_reset();
        #1;
        check_outputs();
        tick();
        Reset = 1'b1;
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
